// File: rtl/fir_pkg.sv
// Shared constants and encodings for the FIR coefficient store.
//  TAP_NUM_DEF / COEFF_W_DEF / ADDR_W_DEF / SUM_W_DEF : default geometry
//  ld_state_e : loader FSM encoding
//  ERR_*      : err_code values reported by the loader
`timescale 1ns/1ps
package fir_pkg;

  localparam int unsigned TAP_NUM_DEF = 321;
  localparam int unsigned COEFF_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF  = 9;
  localparam int unsigned SUM_W_DEF   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SWAP  = 2'd3
  } ld_state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;

endpackage

// File: rtl/fir_coeff_bank.sv
// One coefficient bank: synchronous write port and registered read port.
//  clk, reset_n : clock, async active-low reset (read register only)
//  we_i, waddr_i, wdata_i : write port
//  raddr_i      : read index
//  rdata_o      : mem[raddr_i] one cycle later, 0 for out-of-range indices
`timescale 1ns/1ps
module fir_coeff_bank #(
  parameter int unsigned DEPTH  = 321,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset; the loader only exposes it after a commit.
  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read with a range guard so a wide index never reads past the array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (32'(raddr_i) < DEPTH) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader: streams a coefficient set into the shadow bank and
// swaps it into the active bank only after exactly TAP_NUM words ending with
// s_last, so the filter never sees a partial set.
//  clk, reset_n          : clock, async active-low reset
//  load_start            : begin a load (ignored while busy)
//  s_valid/s_ready/s_data/s_last : coefficient word stream
//  rd_addr / rd_data     : filter read port on the active bank, 1-cycle latency
//  coeff_valid           : a set has been committed since reset
//  coeff_sum             : signed sum of the committed set
//  busy / done / err     : FSM not idle / commit pulse / reject pulse
//  err_code              : reason of the last reject, cleared by load_start
`timescale 1ns/1ps
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int unsigned TAP_NUM = TAP_NUM_DEF,
  parameter int unsigned COEFF_W = COEFF_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned SUM_W   = SUM_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [COEFF_W-1:0] s_data,
  input  logic               s_last,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COEFF_W-1:0] rd_data,
  output logic               coeff_valid,
  output logic [SUM_W-1:0]   coeff_sum,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);

  ld_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  widx_q, widx_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   coeff_sum_q, coeff_sum_d;
  logic               coeff_valid_q, coeff_valid_d;
  logic               bank_sel_q, bank_sel_d;
  logic               s_ready_q, s_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               rd_ok_q, rd_ok_d;
  logic               rd_sel_q;
  logic               beat_c, last_idx_c, wr_en_c;
  logic [COEFF_W-1:0] rdata0_c, rdata1_c;

  // State and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      widx_q        <= '0;
      acc_q         <= '0;
      coeff_sum_q   <= '0;
      coeff_valid_q <= 1'b0;
      bank_sel_q    <= 1'b0;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      rd_ok_q       <= 1'b0;
      rd_sel_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      acc_q         <= acc_d;
      coeff_sum_q   <= coeff_sum_d;
      coeff_valid_q <= coeff_valid_d;
      bank_sel_q    <= bank_sel_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      rd_ok_q       <= rd_ok_d;
      // Bank choice travels with the read so a read issued during SWAP sees the old set.
      rd_sel_q      <= bank_sel_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    acc_d         = acc_q;
    coeff_sum_d   = coeff_sum_q;
    coeff_valid_d = coeff_valid_q;
    bank_sel_d    = bank_sel_q;
    err_code_d    = err_code_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    wr_en_c       = 1'b0;
    beat_c        = s_valid && s_ready_q;
    last_idx_c    = (widx_q == ADDR_W'(TAP_NUM - 1));

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          widx_d     = '0;
          acc_d      = '0;
          err_code_d = ERR_NONE;
        end
      end
      ST_LOAD: begin
        if (beat_c) begin
          wr_en_c = 1'b1;
          acc_d   = acc_q + SUM_W'($signed(s_data));
          widx_d  = widx_q + ADDR_W'(1);
          if (s_last && last_idx_c) begin
            state_d = ST_SWAP;
          end else if (s_last) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_SHORT;
          end else if (last_idx_c) begin
            // Shadow bank is full but the set did not end: swallow the rest.
            state_d    = ST_DRAIN;
            err_d      = 1'b1;
            err_code_d = ERR_LONG;
          end
        end
      end
      ST_DRAIN: begin
        if (beat_c && s_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_SWAP: begin
        bank_sel_d    = ~bank_sel_q;
        coeff_sum_d   = acc_q;
        coeff_valid_d = 1'b1;
        done_d        = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    busy_d    = (state_d != ST_IDLE);
    rd_ok_d   = (32'(rd_addr) < TAP_NUM) && coeff_valid_q;
  end

  // bank_sel_q names the active bank; writes always go to the other one.
  fir_coeff_bank #(
    .DEPTH (TAP_NUM),
    .DATA_W(COEFF_W),
    .ADDR_W(ADDR_W)
  ) u_bank0 (
    .clk    (clk),
    .reset_n(reset_n),
    .we_i   (wr_en_c && bank_sel_q),
    .waddr_i(widx_q),
    .wdata_i(s_data),
    .raddr_i(rd_addr),
    .rdata_o(rdata0_c)
  );

  fir_coeff_bank #(
    .DEPTH (TAP_NUM),
    .DATA_W(COEFF_W),
    .ADDR_W(ADDR_W)
  ) u_bank1 (
    .clk    (clk),
    .reset_n(reset_n),
    .we_i   (wr_en_c && !bank_sel_q),
    .waddr_i(widx_q),
    .wdata_i(s_data),
    .raddr_i(rd_addr),
    .rdata_o(rdata1_c)
  );

  // Select between two registered read ports; uncommitted or out-of-range reads give 0.
  assign rd_data     = rd_ok_q ? (rd_sel_q ? rdata1_c : rdata0_c) : '0;
  assign s_ready     = s_ready_q;
  assign coeff_valid = coeff_valid_q;
  assign coeff_sum   = coeff_sum_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Testbench for fir_coeff_loader: read-port scoreboard plus per-scenario tasks.
`timescale 1ns/1ps
module tb_fir_coeff_loader;
  import fir_pkg::*;

  localparam int TAPI = 321;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [15:0] s_data = '0;
  logic [8:0]  rd_addr = '0;
  logic        s_ready, coeff_valid, busy, done, err;
  logic [15:0] rd_data;
  logic [31:0] coeff_sum;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  fir_coeff_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (load_start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .coeff_valid(coeff_valid),
    .coeff_sum  (coeff_sum),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // Model of the active set as the filter should see it.
  logic [15:0] act [TAPI];
  logic [15:0] shd [TAPI];
  logic [31:0] exp_sum  = '0;
  logic [31:0] pend_sum = '0;
  bit          exp_valid = 1'b0;
  int          commit_cd = 0;
  bit          sweep_on  = 1'b0;
  int          sweep_idx = 0;
  logic [15:0] rd_exp_q [$];
  logic [15:0] mon_e;

  // Pulse counters and read scoreboard, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
    if (rd_exp_q.size() > 0) begin
      mon_e = rd_exp_q.pop_front();
      n_checks++;
      if (rd_data !== mon_e) begin
        n_errs++;
        $display("FAIL rd_data: got %0d expected %0d", $signed(rd_data), $signed(mon_e));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] word_of(input int mode, input int k);
    if (mode == 0) return 16'(k - 160);
    if (mode == 1) return 16'd1;
    return 16'($urandom_range(0, 65535));
  endfunction

  // Present a read address at a falling edge and queue what it must return.
  task automatic drive_rd(input int a);
    rd_addr = 9'(a);
    if (a < TAPI && exp_valid) rd_exp_q.push_back(act[a]);
    else rd_exp_q.push_back(16'h0000);
  endtask

  // Advance to the next falling edge, applying a due commit to the model first.
  task automatic cyc();
    @(negedge clk);
    if (commit_cd > 0) begin
      commit_cd--;
      if (commit_cd == 0) begin
        for (int i = 0; i < TAPI; i++) act[i] = shd[i];
        exp_sum   = pend_sum;
        exp_valid = 1'b1;
      end
    end
    if (sweep_on) begin
      drive_rd(sweep_idx % TAPI);
      sweep_idx++;
    end
  endtask

  task automatic send_word(input logic [15:0] d, input bit last, input bit gaps, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = d;
      s_last  = last;
      if (s_valid && s_ready) ok = 1'b1;
      cyc();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errs++;
      $display("FAIL handshake: word not accepted in 64 cycles, s_ready=%0b", s_ready);
    end
  endtask

  task automatic spot_reads(input int n);
    for (int i = 0; i < n; i++) begin
      drive_rd(int'($urandom_range(0, TAPI + 20)));
      cyc();
    end
    cyc();
  endtask

  // Full load sequence of n words; s_last on the final word.
  task automatic load_set(input int n, input int mode, input bit gaps, input bit poke);
    int          dc0, ec0, err_k;
    bit          ok;
    logic [15:0] d;
    logic [31:0] s;
    logic [1:0]  ec_exp;
    dc0 = done_cnt;
    ec0 = err_cnt;
    s   = '0;
    err_k  = (n < TAPI) ? n - 1 : TAPI - 1;
    ec_exp = (n == TAPI) ? ERR_NONE : ((n < TAPI) ? ERR_SHORT : ERR_LONG);
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_errs++; $display("FAIL busy_in_load: got %0b expected 1", busy); end
    for (int k = 0; k < n; k++) begin
      d = word_of(mode, k);
      if (k < TAPI) begin
        shd[k] = d;
        s = s + {{16{d[15]}}, d};
      end
      if (poke && k == 150) load_start = 1'b1;
      send_word(d, k == n - 1, gaps, ok);
      load_start = 1'b0;
      if (!ok) return;
      if (n != TAPI && k == err_k) begin
        n_checks++;
        if (err !== 1'b1 || err_code !== ec_exp) begin
          n_errs++;
          $display("FAIL err_pulse word %0d: got err=%0b code=%0d expected err=1 code=%0d", k, err, err_code, ec_exp);
        end
      end
    end
    if (n == TAPI) begin
      commit_cd = 1;
      pend_sum  = s;
    end
    repeat (4) cyc();
    n_checks++;
    if (done_cnt - dc0 !== ((n == TAPI) ? 1 : 0)) begin
      n_errs++; $display("FAIL done_count: got %0d expected %0d", done_cnt - dc0, (n == TAPI) ? 1 : 0);
    end
    n_checks++;
    if (err_cnt - ec0 !== ((n == TAPI) ? 0 : 1)) begin
      n_errs++; $display("FAIL err_count: got %0d expected %0d", err_cnt - ec0, (n == TAPI) ? 0 : 1);
    end
    n_checks++;
    if (err_code !== ec_exp) begin n_errs++; $display("FAIL err_code: got %0d expected %0d", err_code, ec_exp); end
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      n_errs++; $display("FAIL idle_after_load: got busy=%0b s_ready=%0b expected 0/0", busy, s_ready);
    end
    n_checks++;
    if (coeff_valid !== exp_valid) begin n_errs++; $display("FAIL coeff_valid: got %0b expected %0b", coeff_valid, exp_valid); end
    n_checks++;
    if (coeff_sum !== exp_sum) begin
      n_errs++; $display("FAIL coeff_sum: got %0d expected %0d", $signed(coeff_sum), $signed(exp_sum));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s_ready, busy, done, err, coeff_valid} !== 5'b0 || err_code !== 2'd0 || rd_data !== 16'd0 || coeff_sum !== 32'd0) begin
      n_errs++;
      $display("FAIL reset_values: s_ready=%0b busy=%0b done=%0b err=%0b valid=%0b code=%0d rd=%0d sum=%0d expected all 0",
               s_ready, busy, done, err, coeff_valid, err_code, rd_data, coeff_sum);
    end
    reset_n = 1'b1;
    cyc();
    drive_rd(0);
    cyc();
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      n_errs++; $display("FAIL idle_after_reset: got busy=%0b s_ready=%0b expected 0/0", busy, s_ready);
    end
  endtask

  task automatic test_first_load();
    load_set(TAPI, 0, 1'b0, 1'b0);
    drive_rd(5);
    cyc();
    n_checks++;
    if (rd_data !== 16'hFF65) begin n_errs++; $display("FAIL rd_addr5: got %0d expected -155", $signed(rd_data)); end
    drive_rd(400);
    cyc();
    n_checks++;
    if (rd_data !== 16'h0000) begin n_errs++; $display("FAIL rd_out_of_range: got %0d expected 0", $signed(rd_data)); end
    drive_rd(320);
    cyc();
    drive_rd(0);
    cyc();
    cyc();
  endtask

  task automatic test_sweep_swap();
    sweep_idx = 0;
    sweep_on  = 1'b1;
    load_set(TAPI, 1, 1'b0, 1'b0);
    sweep_on = 1'b0;
    cyc();
    n_checks++;
    if (coeff_sum !== 32'd321) begin n_errs++; $display("FAIL sum_all_ones: got %0d expected 321", $signed(coeff_sum)); end
  endtask

  task automatic test_short();
    load_set(100, 0, 1'b0, 1'b0);
    spot_reads(8);
  endtask

  task automatic test_long();
    load_set(330, 2, 1'b0, 1'b0);
    spot_reads(8);
  endtask

  task automatic test_gaps_and_restart();
    load_set(TAPI, 1, 1'b1, 1'b1);
    spot_reads(10);
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      send_word(word_of(2, k), 1'b0, 1'b0, ok);
      if (!ok) return;
    end
    s_valid = 1'b1;
    s_data  = 16'h1234;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, busy, done, err, coeff_valid} !== 5'b0 || err_code !== 2'd0 || rd_data !== 16'd0 || coeff_sum !== 32'd0) begin
      n_errs++;
      $display("FAIL mid_load_reset: s_ready=%0b busy=%0b done=%0b err=%0b valid=%0b code=%0d rd=%0d sum=%0d expected all 0",
               s_ready, busy, done, err, coeff_valid, err_code, rd_data, coeff_sum);
    end
    exp_valid = 1'b0;
    exp_sum   = '0;
    commit_cd = 0;
    s_valid   = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    drive_rd(5);
    cyc();
    load_set(TAPI, 2, 1'b0, 1'b0);
    spot_reads(10);
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_sweep_swap();
    test_short();
    test_long();
    test_gaps_and_restart();
    test_reset_mid_load();
    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
